pipe_ctrl_n: RTL and testbench

Parametrised pipeline hazard controller for the RV32I core, generalising the fixed six-bit stall controller to an NSTAGE-deep pipeline. It arbitrates per-stage stall requests and branch/exception flush requests into stall, bubble and flush vectors, and provides the PC redirect. It adds a debug halt/single-step state machine that drains the pipeline, plus a saturating stall-cycle counter. Sits beside the stage modules in the core top, driven by the stage stall requests and the EX branch bus.

---
 rtl/pipe_ctrl_n.sv | 136 +++++++++++++
 tb/tb_pipe_ctrl_n.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_n.sv
// Pipeline hazard controller: stall/bubble/flush arbitration across NSTAGE stages,
// PC redirect, debug halt/single-step drain FSM and a saturating stall-cycle counter.
module pipe_ctrl_n #(
  parameter int NSTAGE = 6,
  parameter int FW     = $clog2(NSTAGE),
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic [NSTAGE-1:0] stage_valid,
  input  logic              flush_req,
  input  logic [FW-1:0]     flush_stage,
  input  logic [31:0]       flush_pc,
  input  logic              dbg_halt_req,
  input  logic              dbg_resume,
  input  logic              dbg_step,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic [NSTAGE-1:0] flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;

  state_t            state_reg;
  logic              halted_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [NSTAGE-1:0] older_mask;
  logic [NSTAGE-1:0] eff_req;
  logic [NSTAGE-1:0] stall_arb;
  logic [NSTAGE-1:0] bubble_arb;
  logic [NSTAGE-1:0] flush_arb;
  logic [NSTAGE-1:0] force_stall;
  logic [NSTAGE-1:0] force_bubble;
  logic              flush_acc;
  logic              hold_fetch;
  logic              unused_sv0;

  // The fetch stage never holds a drained instruction, so its valid bit is not consulted.
  assign unused_sv0 = stage_valid[0];

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
      // A stage stalls when it or any older stage requests a stall.
      assign stall_arb[gi] = |eff_req[NSTAGE-1:gi];
      if (gi == 0) begin : g_fetch
        assign older_mask[gi] = 1'b0;
        assign bubble_arb[gi] = 1'b0;
        assign flush_arb[gi]  = 1'b0;
      end else begin : g_rest
        assign older_mask[gi] = (FW'(gi) > flush_stage);
        assign bubble_arb[gi] = stall_arb[gi-1] & ~stall_arb[gi];
        assign flush_arb[gi]  = flush_acc & (FW'(gi) <= flush_stage);
      end
    end
  endgenerate

  // An accepted flush kills every requester at or below F, so no stalls remain.
  always_comb begin
    flush_acc = flush_req & ~(|(stallreq & older_mask));
    eff_req   = flush_acc ? '0 : stallreq;
  end

  always_comb begin
    hold_fetch      = (state_reg == DRAIN) || (state_reg == HALTED);
    force_stall     = '0;
    force_bubble    = '0;
    force_stall[0]  = hold_fetch;
    force_bubble[1] = hold_fetch;
  end

  always_comb begin
    stall          = '0;
    bubble         = '0;
    flush          = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (rst_n) begin
      stall          = stall_arb | force_stall;
      bubble         = bubble_arb | force_bubble;
      flush          = flush_arb;
      redirect_valid = flush_acc;
      redirect_pc    = flush_acc ? flush_pc : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      halted_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      if ((|stall) && (cnt_reg != '1))
        cnt_reg <= cnt_reg + CNT_W'(1);
      case (state_reg)
        RUN: begin
          if (dbg_halt_req)
            state_reg <= DRAIN;
        end
        DRAIN: begin
          if (stage_valid[NSTAGE-1:1] == '0) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end
        end
        HALTED: begin
          if (dbg_step) begin
            state_reg  <= STEP;
            halted_reg <= 1'b0;
          end else if (dbg_resume && !dbg_halt_req) begin
            state_reg  <= RUN;
            halted_reg <= 1'b0;
          end
        end
        STEP: begin
          // Remain here until the single fetch actually goes through.
          if (!stall_arb[0])
            state_reg <= DRAIN;
        end
        default: begin
          state_reg  <= RUN;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  assign halted       = halted_reg;
  assign stall_cycles = cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Self-checking bench for pipe_ctrl_n: table of combinational arbitration vectors,
// then hand-written debug halt/step, counter saturation and async reset sequences.
module tb_pipe_ctrl_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stallreq;
  logic [5:0]  stage_valid;
  logic        flush_req;
  logic [2:0]  flush_stage;
  logic [31:0] flush_pc;
  logic        dbg_halt_req;
  logic        dbg_resume;
  logic        dbg_step;

  logic [5:0]  stall, bubble, flush;
  logic        redirect_valid, halted;
  logic [31:0] redirect_pc, stall_cycles;

  logic [5:0]  stall4, bubble4, flush4;
  logic        redirect_valid4, halted4;
  logic [31:0] redirect_pc4;
  logic [3:0]  stall_cycles4;

  int          n_vec = 0;
  int          n_err = 0;
  logic [5:0]  last_exp_stall = '0;
  logic [31:0] exp_cnt = '0;
  logic [3:0]  exp_cnt4 = '0;

  always #5 clk = ~clk;

  pipe_ctrl_n #(.NSTAGE(6), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stallreq(stallreq), .stage_valid(stage_valid),
    .flush_req(flush_req), .flush_stage(flush_stage), .flush_pc(flush_pc),
    .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume), .dbg_step(dbg_step),
    .stall(stall), .bubble(bubble), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted), .stall_cycles(stall_cycles)
  );

  pipe_ctrl_n #(.NSTAGE(6), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stallreq(stallreq), .stage_valid(stage_valid),
    .flush_req(flush_req), .flush_stage(flush_stage), .flush_pc(flush_pc),
    .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume), .dbg_step(dbg_step),
    .stall(stall4), .bubble(bubble4), .flush(flush4), .redirect_valid(redirect_valid4),
    .redirect_pc(redirect_pc4), .halted(halted4), .stall_cycles(stall_cycles4)
  );

  typedef struct {
    logic [5:0]  sreq;
    logic        freq;
    logic [2:0]  fst;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic [5:0]  e_bubble;
    logic [5:0]  e_flush;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[11];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_now(input string name, input logic [5:0] es, input logic [5:0] eb,
                         input logic [5:0] ef, input logic erv, input logic [31:0] erpc,
                         input logic eh);
    cmp({name, ".stall"},  32'(stall),  32'(es));
    cmp({name, ".bubble"}, 32'(bubble), 32'(eb));
    cmp({name, ".flush"},  32'(flush),  32'(ef));
    cmp({name, ".rv"},     32'(redirect_valid), 32'(erv));
    cmp({name, ".rpc"},    redirect_pc, erpc);
    cmp({name, ".halted"}, 32'(halted), 32'(eh));
    last_exp_stall = es;
    $display("%s: stall=%b bubble=%b flush=%b rv=%b rpc=0x%0h halted=%b",
             name, stall, bubble, flush, redirect_valid, redirect_pc, halted);
  endtask

  task automatic chk_out(input string name, input logic [5:0] es, input logic [5:0] eb,
                         input logic [5:0] ef, input logic erv, input logic [31:0] erpc,
                         input logic eh);
    @(negedge clk);
    chk_now(name, es, eb, ef, erv, erpc, eh);
  endtask

  // Advance one clock; the counters' model follows the stall value just checked.
  task automatic step();
    if (last_exp_stall != 0) begin
      if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      if (exp_cnt4 != 4'hF) exp_cnt4++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_chk(input string name, input logic eh);
    chk_out(name, 6'b000001, 6'b000010, 6'b0, 1'b0, 32'h0, eh);
  endtask

  initial begin
    // stallreq, freq, F, pc, stall, bubble, flush, rv, rpc
    vecs[0]  = '{6'b000100, 1'b0, 3'd0, 32'h0,    6'b000111, 6'b001000, 6'b000000, 1'b0, 32'h0};
    vecs[1]  = '{6'b000000, 1'b0, 3'd0, 32'h0,    6'b000000, 6'b000000, 6'b000000, 1'b0, 32'h0};
    vecs[2]  = '{6'b100000, 1'b0, 3'd0, 32'h0,    6'b111111, 6'b000000, 6'b000000, 1'b0, 32'h0};
    vecs[3]  = '{6'b000001, 1'b0, 3'd0, 32'h0,    6'b000001, 6'b000010, 6'b000000, 1'b0, 32'h0};
    vecs[4]  = '{6'b000010, 1'b1, 3'd3, 32'h80,   6'b000000, 6'b000000, 6'b001110, 1'b1, 32'h80};
    vecs[5]  = '{6'b010000, 1'b1, 3'd3, 32'h80,   6'b011111, 6'b100000, 6'b000000, 1'b0, 32'h0};
    vecs[6]  = '{6'b000000, 1'b1, 3'd3, 32'h80,   6'b000000, 6'b000000, 6'b001110, 1'b1, 32'h80};
    vecs[7]  = '{6'b100001, 1'b1, 3'd5, 32'h1234, 6'b000000, 6'b000000, 6'b111110, 1'b1, 32'h1234};
    vecs[8]  = '{6'b000001, 1'b1, 3'd0, 32'h44,   6'b000000, 6'b000000, 6'b000000, 1'b1, 32'h44};
    vecs[9]  = '{6'b000010, 1'b1, 3'd0, 32'h44,   6'b000011, 6'b000100, 6'b000000, 1'b0, 32'h0};
    vecs[10] = '{6'b001000, 1'b1, 3'd4, 32'h200,  6'b000000, 6'b000000, 6'b011110, 1'b1, 32'h200};

    rst_n = 1'b0;
    stallreq = 6'b000100; stage_valid = '0;
    flush_req = 1'b1; flush_stage = 3'd3; flush_pc = 32'h80;
    dbg_halt_req = 1'b0; dbg_resume = 1'b0; dbg_step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 6'b0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    cmp("reset.cnt", stall_cycles, 32'h0);
    #1 rst_n = 1'b1;
    flush_req = 1'b0; stallreq = '0;
    step();

    for (int i = 0; i < 11; i++) begin
      stallreq = vecs[i].sreq; flush_req = vecs[i].freq;
      flush_stage = vecs[i].fst; flush_pc = vecs[i].fpc;
      chk_out($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_bubble,
              vecs[i].e_flush, vecs[i].e_rv, vecs[i].e_rpc, 1'b0);
      step();
    end
    cmp("table.cnt", stall_cycles, exp_cnt);
    stallreq = '0; flush_req = 1'b0; flush_stage = 3'd0; flush_pc = '0;

    // Halt: drain with older stages retiring one per cycle.
    dbg_halt_req = 1'b1; stage_valid = 6'b111110;
    chk_out("halt_req", 6'b0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 6; i++) begin
      stage_valid = 6'b111110 << i;
      hold_chk($sformatf("drain%0d", i), 1'b0);
      step();
    end
    hold_chk("halted", 1'b1);
    step();
    flush_req = 1'b1; flush_stage = 3'd3; flush_pc = 32'h40;
    chk_out("halt_flush", 6'b000001, 6'b000010, 6'b001110, 1'b1, 32'h40, 1'b1);
    step();
    flush_req = 1'b0;
    dbg_resume = 1'b1;
    hold_chk("resume_blocked", 1'b1);
    step();
    dbg_resume = 1'b0; dbg_step = 1'b1;
    hold_chk("step_req", 1'b1);
    step();
    dbg_step = 1'b0;
    chk_out("step", 6'b0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 6; i++) begin
      stage_valid = (i < 5) ? (6'b000010 << i) : 6'b0;
      hold_chk($sformatf("step_drain%0d", i), 1'b0);
      step();
    end
    stallreq = 6'b000001; dbg_step = 1'b1;
    hold_chk("halted2", 1'b1);
    step();
    dbg_step = 1'b0;
    chk_out("step_stalled", 6'b000001, 6'b000010, 6'b0, 1'b0, 32'h0, 1'b0);
    step();
    stallreq = '0;
    chk_out("step_retry", 6'b0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    step();
    hold_chk("step_redrain", 1'b0);
    step();
    dbg_halt_req = 1'b0; dbg_resume = 1'b1;
    hold_chk("halted3", 1'b1);
    step();
    dbg_resume = 1'b0;
    chk_out("resumed", 6'b0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    cmp("debug.cnt", stall_cycles, exp_cnt);
    step();

    // Counter saturation on the 4-bit instance.
    stallreq = 6'b000010;
    #1 rst_n = 1'b0;
    #1;
    chk_now("sat_rst", 6'b0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    cmp("sat_rst.cnt4", 32'(stall_cycles4), 32'h0);
    #1 rst_n = 1'b1;
    exp_cnt = '0; exp_cnt4 = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmp($sformatf("sat%0d.stall", i), 32'(stall), 32'h3);
      last_exp_stall = 6'b000011;
      step();
    end
    $display("sat: stall_cycles=%0d stall_cycles4=%0d", stall_cycles, stall_cycles4);
    cmp("sat.cnt4", 32'(stall_cycles4), 32'd15);
    cmp("sat.model4", 32'(stall_cycles4), 32'(exp_cnt4));
    cmp("sat.cnt", stall_cycles, 32'd20);

    // Asynchronous reset mid-DRAIN.
    stallreq = '0; dbg_halt_req = 1'b1; stage_valid = 6'b111110;
    chk_out("pre_drain", 6'b0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    step();
    hold_chk("mid_drain", 1'b0);
    rst_n = 1'b0;
    #1;
    chk_now("async_rst", 6'b0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    cmp("async_rst.cnt", stall_cycles, 32'h0);
    dbg_halt_req = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk_now("post_rst_run", 6'b0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    exp_cnt = '0; exp_cnt4 = '0;
    step();
    dbg_halt_req = 1'b1;
    chk_out("rehalt", 6'b0, 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    step();
    hold_chk("redrain", 1'b0);
    step();
    cmp("redrain.cnt", stall_cycles, exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
